// File: rtl/ddr_arb_pkg.sv
// ============================================================================
// Module      : ddr_arb_pkg
// Description : Shared state encoding and sizing helpers for the DDR
//               transaction arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ddr_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_e;

    // Counter/index width for a range of n values, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker; searches upward from the
//               slot after i_ptr and returns one-hot grant plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        int k;
        k       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(i_ptr) + i) % N;
            if (!o_any && i_req[k]) begin
                o_any      = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = IDX_W'(k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ddr_txn_arbiter.sv
// ============================================================================
// Module      : ddr_txn_arbiter
// Description : Round-robin sharing of one DDR AXI4 master between compute
//               engines; launches the txn, waits for done, answers the winner.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ddr_txn_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 8,
    parameter int INIT_CYC    = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        req_wr_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len_i,
    output logic [NUM_REQ-1:0]        rsp_done_o,
    output logic [NUM_REQ-1:0]        rsp_err_o,
    output logic                      txn_init_o,
    output logic                      txn_wr_o,
    output logic [ADDR_W-1:0]         txn_addr_o,
    output logic [LEN_W-1:0]          txn_len_o,
    input  logic                      txn_done_i,
    input  logic                      txn_error_i,
    output logic                      busy_o,
    output logic                      timeout_o,
    output logic [31:0]               txn_count_o
);

    localparam int GRANT_W    = cnt_w(NUM_REQ);
    localparam int INIT_CNT_W = cnt_w(INIT_CYC);
    localparam int TO_CNT_W   = cnt_w(TIMEOUT_CYC);

    localparam logic [GRANT_W-1:0]    c_ptr_rst   = GRANT_W'(NUM_REQ - 1);
    localparam logic [INIT_CNT_W-1:0] c_init_last = INIT_CNT_W'(INIT_CYC - 1);
    localparam logic [TO_CNT_W-1:0]   c_to_last   = TO_CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam bit                    c_to_en     = (TIMEOUT_CYC != 0);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } txn_req_t;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [NUM_REQ-1:0]      w_grant_oh;
    logic [GRANT_W-1:0]      w_grant_idx;
    logic                    w_grant_any;
    txn_req_t                w_sel;
    txn_req_t                r_txn;
    logic [NUM_REQ-1:0]      r_grant_oh;
    logic [GRANT_W-1:0]      r_ptr;
    logic [INIT_CNT_W-1:0]   r_init_cnt;
    logic [TO_CNT_W-1:0]     r_to_cnt;
    logic                    r_done_q;
    logic                    r_err;
    logic                    r_timeout;
    logic [31:0]             r_count;
    logic                    w_done_rise;
    logic                    w_init_last;
    logic                    w_to_hit;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (GRANT_W)
    ) u_rr (
        .i_req   (req_i),
        .i_ptr   (r_ptr),
        .o_grant (w_grant_oh),
        .o_idx   (w_grant_idx),
        .o_any   (w_grant_any)
    );

    always_comb begin
        w_sel      = '0;
        w_sel.wr   = req_wr_i[w_grant_idx];
        w_sel.addr = req_addr_i[int'(w_grant_idx)*ADDR_W +: ADDR_W];
        w_sel.len  = req_len_i[int'(w_grant_idx)*LEN_W +: LEN_W];
    end

    // r_done_q tracks the level continuously, so a done still high from the
    // previous txn on WAIT entry never looks like a fresh completion.
    assign w_done_rise = txn_done_i & ~r_done_q;
    assign w_init_last = (r_init_cnt == c_init_last);
    assign w_to_hit    = c_to_en && (r_to_cnt == c_to_last);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|req_i) w_state_nxt = ARB;
            ARB:     w_state_nxt = w_grant_any ? LAUNCH : IDLE;
            LAUNCH:  if (w_init_last) w_state_nxt = WAIT;
            WAIT:    if (w_done_rise || w_to_hit) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_txn      <= '0;
            r_grant_oh <= '0;
            r_ptr      <= c_ptr_rst;
            r_init_cnt <= '0;
            r_to_cnt   <= '0;
            r_done_q   <= 1'b0;
            r_err      <= 1'b0;
            r_timeout  <= 1'b0;
            r_count    <= '0;
        end else begin
            r_done_q <= txn_done_i;
            case (r_state)
                ARB: begin
                    if (w_grant_any) begin
                        r_txn      <= w_sel;
                        r_grant_oh <= w_grant_oh;
                        r_ptr      <= w_grant_idx;
                    end
                end
                LAUNCH: begin
                    r_init_cnt <= w_init_last ? '0 : r_init_cnt + INIT_CNT_W'(1);
                end
                WAIT: begin
                    if (w_done_rise) begin
                        r_err    <= txn_error_i;
                        r_to_cnt <= '0;
                    end else if (w_to_hit) begin
                        r_err     <= 1'b1;
                        r_timeout <= 1'b1;
                        r_to_cnt  <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
                    end
                end
                RESP: begin
                    r_count <= r_count + 32'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign txn_init_o  = (r_state == LAUNCH);
    assign busy_o      = (r_state != IDLE);
    assign rsp_done_o  = (r_state == RESP) ? r_grant_oh : '0;
    assign rsp_err_o   = ((r_state == RESP) && r_err) ? r_grant_oh : '0;
    assign txn_wr_o    = r_txn.wr;
    assign txn_addr_o  = r_txn.addr;
    assign txn_len_o   = r_txn.len;
    assign timeout_o   = r_timeout;
    assign txn_count_o = r_count;

endmodule

`default_nettype wire

// File: tb/tb_ddr_txn_arbiter.sv
// ============================================================================
// Module      : tb_ddr_txn_arbiter
// Description : Directed self-checking bench for ddr_txn_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ddr_txn_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int ADDR_W      = 32;
    localparam int LEN_W       = 8;
    localparam int INIT_CYC    = 2;
    localparam int TIMEOUT_CYC = 64;

    logic                      ACLK = 1'b0;
    logic                      ARESETN = 1'b0;
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ-1:0]        req_wr_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*LEN_W-1:0]  req_len_i;
    logic [NUM_REQ-1:0]        rsp_done_o;
    logic [NUM_REQ-1:0]        rsp_err_o;
    logic                      txn_init_o;
    logic                      txn_wr_o;
    logic [ADDR_W-1:0]         txn_addr_o;
    logic [LEN_W-1:0]          txn_len_o;
    logic                      txn_done_i;
    logic                      txn_error_i;
    logic                      busy_o;
    logic                      timeout_o;
    logic [31:0]               txn_count_o;

    int n_asserts = 0;
    int n_fail    = 0;

    assign req_wr_i   = 4'b1010;
    assign req_addr_i = {32'hFFFF_FFC0, 32'h0000_3300, 32'h0000_2040, 32'h0000_0100};
    assign req_len_i  = {8'd1, 8'd255, 8'd4, 8'd16};

    always #5 ACLK = ~ACLK;

    ddr_txn_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ADDR_W      (ADDR_W),
        .LEN_W       (LEN_W),
        .INIT_CYC    (INIT_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .req_i       (req_i),
        .req_wr_i    (req_wr_i),
        .req_addr_i  (req_addr_i),
        .req_len_i   (req_len_i),
        .rsp_done_o  (rsp_done_o),
        .rsp_err_o   (rsp_err_o),
        .txn_init_o  (txn_init_o),
        .txn_wr_o    (txn_wr_o),
        .txn_addr_o  (txn_addr_o),
        .txn_len_o   (txn_len_o),
        .txn_done_i  (txn_done_i),
        .txn_error_i (txn_error_i),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o),
        .txn_count_o (txn_count_o)
    );

    function automatic logic [31:0] exp_addr(input int k);
        case (k)
            0:       return 32'h0000_0100;
            1:       return 32'h0000_2040;
            2:       return 32'h0000_3300;
            default: return 32'hFFFF_FFC0;
        endcase
    endfunction

    function automatic logic [7:0] exp_len(input int k);
        case (k)
            0:       return 8'd16;
            1:       return 8'd4;
            2:       return 8'd255;
            default: return 8'd1;
        endcase
    endfunction

    function automatic logic exp_wr(input int k);
        return (k == 1) || (k == 3);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge ACLK);
        ARESETN     = 1'b0;
        req_i       = '0;
        txn_done_i  = 1'b0;
        txn_error_i = 1'b0;
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    // Waits for the init pulse, checks the latched fields and the pulse width.
    // Returns at the first WAIT-state negedge.
    task automatic wait_launch(input int eng, input bit clr_done, output int lat);
        int w;
        lat = 0;
        do begin
            @(negedge ACLK);
            lat++;
        end while (!txn_init_o && lat < 20);
        check_eq("init_seen", {63'd0, txn_init_o}, 64'd1);
        if (clr_done) begin
            txn_done_i  = 1'b0;
            txn_error_i = 1'b0;
        end
        check_eq("txn_addr", {32'd0, txn_addr_o}, {32'd0, exp_addr(eng)});
        check_eq("txn_len", {56'd0, txn_len_o}, {56'd0, exp_len(eng)});
        check_eq("txn_wr", {63'd0, txn_wr_o}, {63'd0, exp_wr(eng)});
        w = 0;
        while (txn_init_o && w < 10) begin
            w++;
            @(negedge ACLK);
        end
        check_eq("init_width", 64'(w), 64'(INIT_CYC));
        check_eq("addr_hold", {32'd0, txn_addr_o}, {32'd0, exp_addr(eng)});
    endtask

    task automatic do_done(input int eng, input bit err, input int dly, input logic [3:0] drop);
        logic [3:0] oh;
        oh = 4'(1 << eng);
        repeat (dly) @(negedge ACLK);
        txn_done_i  = 1'b1;
        txn_error_i = err;
        @(negedge ACLK);
        check_eq("rsp_done", {60'd0, rsp_done_o}, {60'd0, oh});
        check_eq("rsp_err", {60'd0, rsp_err_o}, {60'd0, (err ? oh : 4'b0000)});
        req_i = req_i & ~drop;
        @(negedge ACLK);
        check_eq("rsp_done_pulse", {60'd0, rsp_done_o}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        int  n;
        bit  seen;
        req_i       = '0;
        txn_done_i  = 1'b0;
        txn_error_i = 1'b0;
        ARESETN     = 1'b0;
        repeat (3) @(negedge ACLK);

        check_eq("rst_busy", {63'd0, busy_o}, 64'd0);
        check_eq("rst_init", {63'd0, txn_init_o}, 64'd0);
        check_eq("rst_rsp", {56'd0, rsp_done_o, rsp_err_o}, 64'd0);
        check_eq("rst_addr", {32'd0, txn_addr_o}, 64'd0);
        check_eq("rst_count", {32'd0, txn_count_o}, 64'd0);
        check_eq("rst_timeout", {63'd0, timeout_o}, 64'd0);
        ARESETN = 1'b1;

        // 1: single read on engine 0
        @(negedge ACLK);
        req_i = 4'b0001;
        wait_launch(0, 1'b1, lat);
        check_eq("t1_latency", 64'(lat), 64'd2);
        do_done(0, 1'b0, 8, 4'b0001);
        check_eq("t1_count", {32'd0, txn_count_o}, 64'd1);
        check_eq("t1_idle", {63'd0, busy_o}, 64'd0);

        // 2: all engines held, round-robin order 0,1,2,3,0
        apply_reset();
        req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_launch(i % 4, 1'b1, lat);
            do_done(i % 4, 1'b0, 2 + i, (i == 4) ? 4'b1111 : 4'b0000);
        end
        check_eq("t2_count", {32'd0, txn_count_o}, 64'd5);

        // 3: AXI error on engine 2
        apply_reset();
        req_i = 4'b0100;
        wait_launch(2, 1'b1, lat);
        do_done(2, 1'b1, 5, 4'b0100);
        check_eq("t3_timeout", {63'd0, timeout_o}, 64'd0);
        check_eq("t3_count", {32'd0, txn_count_o}, 64'd1);

        // 4: done never rises -> timeout after 64 WAIT cycles
        req_i = 4'b0001;
        wait_launch(0, 1'b1, lat);
        n = 0;
        while (rsp_done_o == '0 && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        check_eq("t4_to_cycles", 64'(n), 64'd64);
        check_eq("t4_rsp_done", {60'd0, rsp_done_o}, 64'h1);
        check_eq("t4_rsp_err", {60'd0, rsp_err_o}, 64'h1);
        check_eq("t4_timeout", {63'd0, timeout_o}, 64'd1);
        req_i = '0;
        repeat (10) @(negedge ACLK);
        check_eq("t4_sticky", {63'd0, timeout_o}, 64'd1);
        check_eq("t4_count", {32'd0, txn_count_o}, 64'd2);
        apply_reset();
        check_eq("t4_cleared", {63'd0, timeout_o}, 64'd0);

        // 5: stale done level held into the next WAIT
        req_i = 4'b0011;
        wait_launch(0, 1'b1, lat);
        do_done(0, 1'b0, 3, 4'b0001);
        wait_launch(1, 1'b0, lat);
        seen = 1'b0;
        repeat (6) begin
            @(negedge ACLK);
            seen = seen | (|rsp_done_o);
        end
        check_eq("t5_no_stale", {63'd0, seen}, 64'd0);
        check_eq("t5_busy", {63'd0, busy_o}, 64'd1);
        txn_done_i = 1'b0;
        @(negedge ACLK);
        do_done(1, 1'b0, 0, 4'b0010);
        check_eq("t5_count", {32'd0, txn_count_o}, 64'd2);

        // 6: async reset mid-WAIT, then engine 1 wins from 1010
        req_i = 4'b0001;
        wait_launch(0, 1'b1, lat);
        repeat (3) @(negedge ACLK);
        check_eq("t6_pre_busy", {63'd0, busy_o}, 64'd1);
        ARESETN = 1'b0;
        #1;
        check_eq("t6_busy", {63'd0, busy_o}, 64'd0);
        check_eq("t6_addr", {32'd0, txn_addr_o}, 64'd0);
        check_eq("t6_len_wr", {55'd0, txn_len_o, txn_wr_o}, 64'd0);
        check_eq("t6_count", {32'd0, txn_count_o}, 64'd0);
        check_eq("t6_rsp", {56'd0, rsp_done_o, rsp_err_o}, 64'd0);
        req_i = '0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        req_i = 4'b1010;
        wait_launch(1, 1'b1, lat);
        check_eq("t6_latency", 64'(lat), 64'd2);
        do_done(1, 1'b0, 4, 4'b1010);
        check_eq("t6_final_count", {32'd0, txn_count_o}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
